// File: rtl/gf2m_mul_sched.sv
// gf2m_mul_sched: round-robin scheduler sharing one external 193-bit
// GF(2)[x] multiplier between NREQ requesters, one job in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/ready     per-requester operand handshake (ready one-hot)
//   req_a, req_b        packed operands, requester i at [193*i +: 193]
//   mul_a, mul_b        registered operands to the multiplier
//   mul_y               385-bit multiplier product
//   rsp_valid/ready     result handshake
//   rsp_id, rsp_data    owner of the result and the product
//   busy                high whenever a job is in flight
//
// Optional build macro GF_REDUCE_EN: adds a RED state that reduces the
// product mod x^193+x^15+1; rsp_data becomes 193 bits wide.
module gf2m_mul_sched #(
   parameter int NREQ       = 2,
   parameter int IDW        = 1,
   parameter int MUL_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*193-1:0] req_a,
   input  logic [NREQ*193-1:0] req_b,
   output logic [192:0]        mul_a,
   output logic [192:0]        mul_b,
   input  logic [384:0]        mul_y,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
`ifdef GF_REDUCE_EN
   output logic [192:0]        rsp_data,
`else
   output logic [384:0]        rsp_data,
`endif
   output logic                busy
);

   localparam int OPW = 193;

`ifdef GF_REDUCE_EN
   localparam int RES_W = 193;
`else
   localparam int RES_W = 385;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
`ifdef GF_REDUCE_EN
      , RED = 2'd3
`endif
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       cnt_q;
   logic [IDW-1:0]   last_q;
   logic [IDW-1:0]   gnt_q;
   logic [RES_W-1:0] res_q;
`ifdef GF_REDUCE_EN
   logic [384:0]     prod_q;
`endif

   logic             any_req;
   logic [IDW-1:0]   gnt_idx;
   logic [OPW-1:0]   sel_a;
   logic [OPW-1:0]   sel_b;
   logic             take;

`ifdef GF_REDUCE_EN
   // Two folding passes: x^193 == x^15 + 1. The first pass leaves at
   // most bits 193..206 set; the second pass clears those.
   function automatic logic [192:0] gf_reduce(input logic [384:0] p);
      logic [206:0] t;
      logic [192:0] r;
      t = {14'b0, p[192:0]};
      for (int i = 193; i < 385; i++) begin
         t[i-193] = t[i-193] ^ p[i];
         t[i-178] = t[i-178] ^ p[i];
      end
      r = t[192:0];
      for (int i = 193; i < 207; i++) begin
         r[i-193] = r[i-193] ^ t[i];
         r[i-178] = r[i-178] ^ t[i];
      end
      return r;
   endfunction
`endif

   // Rotating priority: distance from last grant, 1 is highest and the
   // last grantee itself ranks lowest (distance NREQ).
   always_comb begin
      int d;
      int best;
      any_req = 1'b0;
      gnt_idx = '0;
      best    = NREQ + 1;
      d       = 0;
      for (int i = 0; i < NREQ; i++) begin
         d = i - int'(last_q);
         if (d <= 0) d = d + NREQ;
         if (req_valid[i] && d < best) begin
            best    = d;
            any_req = 1'b1;
            gnt_idx = IDW'(i);
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a = req_a[i*OPW +: OPW];
            sel_b = req_b[i*OPW +: OPW];
         end
      end
   end

   assign take = (state_q == IDLE) && any_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (any_req) state_d = WAIT;
            // ready is combinational; gate with reset so it reads 0
            // while the block is held in reset
            for (int i = 0; i < NREQ; i++) begin
               req_ready[i] = rst_n && any_req
                              && (gnt_idx == IDW'(i));
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
`ifdef GF_REDUCE_EN
               state_d = RED;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef GF_REDUCE_EN
         RED: begin
            state_d = DONE;
         end
`endif
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rsp_id   = gnt_q;
   assign rsp_data = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a  <= '0;
         mul_b  <= '0;
         gnt_q  <= '0;
         last_q <= IDW'(NREQ - 1);
         cnt_q  <= '0;
         res_q  <= '0;
`ifdef GF_REDUCE_EN
         prod_q <= '0;
`endif
      end else begin
         if (take) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            gnt_q  <= gnt_idx;
            last_q <= gnt_idx;
            cnt_q  <= 4'(MUL_CYCLES - 1);
         end
         if (state_q == WAIT) begin
            if (cnt_q != 4'd0) begin
               cnt_q <= cnt_q - 4'd1;
            end else begin
`ifdef GF_REDUCE_EN
               prod_q <= mul_y;
`else
               res_q  <= mul_y;
`endif
            end
         end
`ifdef GF_REDUCE_EN
         if (state_q == RED) begin
            res_q <= gf_reduce(prod_q);
         end
`endif
      end
   end

endmodule

// File: tb/tb_gf2m_mul_sched.sv
// tb_gf2m_mul_sched: randomized self-checking bench for gf2m_mul_sched
// with a behavioural carry-less multiplier and polynomial-mod model.
`timescale 1ns/1ps
module tb_gf2m_mul_sched;
   localparam int NREQ = 2;
   localparam int IDW  = 1;
   localparam int MC   = 3;
   localparam int W    = 193;
   localparam int PW   = 385;
`ifdef GF_REDUCE_EN
   localparam int RES_W = 193;
   localparam int EXTRA = 1;
`else
   localparam int RES_W = 385;
   localparam int EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREQ-1:0]   req_valid, req_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [W-1:0]      mul_a, mul_b;
   logic [PW-1:0]     mul_y;
   logic              rsp_valid, rsp_ready, busy;
   logic [IDW-1:0]    rsp_id;
   logic [RES_W-1:0]  rsp_data;

   logic [NREQ-1:0]   req_valid_e, req_ready_e;
   logic [NREQ*W-1:0] req_a_e, req_b_e;
   logic [W-1:0]      mul_a_e, mul_b_e;
   logic [PW-1:0]     mul_y_e;
   logic              rsp_valid_e, rsp_ready_e, busy_e;
   logic [IDW-1:0]    rsp_id_e;
   logic [RES_W-1:0]  rsp_data_e;

   int checks   = 0;
   int failures = 0;

   function automatic logic [PW-1:0] clmul(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < W; i++)
         if (b[i]) p = p ^ ({{(PW-W){1'b0}}, a} << i);
      return p;
   endfunction

   // Long division by f(x) = x^193 + x^15 + 1, top bit down.
   function automatic logic [RES_W-1:0] exp_res(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [PW-1:0] p;
      p = clmul(a, b);
`ifdef GF_REDUCE_EN
      for (int i = PW - 1; i >= W; i--) begin
         if (p[i]) begin
            p[i]       = 1'b0;
            p[i - 178] = ~p[i - 178];
            p[i - 193] = ~p[i - 193];
         end
      end
`endif
      return p[RES_W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [223:0] t;
      for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   assign mul_y   = clmul(mul_a, mul_b);
   assign mul_y_e = clmul(mul_a_e, mul_b_e);

   gf2m_mul_sched #(.NREQ(NREQ), .IDW(IDW), .MUL_CYCLES(MC)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   gf2m_mul_sched #(.NREQ(NREQ), .IDW(IDW), .MUL_CYCLES(1)) u_edge (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_e), .req_ready(req_ready_e),
      .req_a(req_a_e), .req_b(req_b_e),
      .mul_a(mul_a_e), .mul_b(mul_b_e), .mul_y(mul_y_e),
      .rsp_valid(rsp_valid_e), .rsp_ready(rsp_ready_e),
      .rsp_id(rsp_id_e), .rsp_data(rsp_data_e), .busy(busy_e)
   );

   // Raise valid for requester r and wait (bounded) for its ready.
   task automatic send(input int r, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int n);
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
      req_valid[r]    = 1'b1;
      #1;
      n = 0;
      while (!req_ready[r] && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
   endtask

   // Step past the accepting edge, then wait (bounded) for rsp_valid.
   // lat = edges from acceptance to the edge raising rsp_valid.
   task automatic wait_rsp(input bit drop, output int lat, output int bad);
      int k;
      @(negedge clk);
      if (drop) req_valid = '0;
      #1;
      k   = 1;
      bad = 0;
      while (!rsp_valid && k < 60) begin
         if (!busy || req_ready != '0) bad++;
         @(negedge clk); #1;
         k++;
      end
      lat = k - 1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_a     = {rnd(), rnd()};
      req_b     = {rnd(), rnd()};
      req_valid = 2'b11;
      @(negedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid, busy} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctrl: rdy/valid/busy=%b, want 0000",
                  {req_ready, rsp_valid, busy});
      end
      checks++;
      if (mul_a !== '0 || mul_b !== '0 || rsp_id !== '0
          || rsp_data !== '0) begin
         failures++;
         $display("FAIL reset_data: mul_a=%h rsp_id=%0d rsp_data=%h, want 0",
                  mul_a, rsp_id, rsp_data);
      end
      req_valid = '0;
      rst_n     = 1'b1;
   endtask

   task automatic test_basic();
      int n, lat, bad;
      @(negedge clk);
      rsp_ready = 1'b1;
      send(0, W'(1), W'(1), n);
      checks++;
      if (n != 0 || req_ready !== 2'b01) begin
         failures++;
         $display("FAIL basic_grant: req_ready=%b wait=%0d, want 01 wait=0",
                  req_ready, n);
      end
      wait_rsp(1'b1, lat, bad);
      checks++;
      if (lat != MC + EXTRA || bad != 0) begin
         failures++;
         $display("FAIL basic_latency: lat=%0d bad=%0d, want lat=%0d bad=0",
                  lat, bad, MC + EXTRA);
      end
      checks++;
      if (rsp_id !== 1'b0 || rsp_data !== RES_W'(1) || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_rsp: id=%0d data=%h busy=%b, want 0 1 1",
                  rsp_id, rsp_data, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_release: valid=%b busy=%b, want 0 0",
                  rsp_valid, busy);
      end
   endtask

   task automatic test_reduce_boundary();
      int n, lat, bad;
      logic [W-1:0] a;
      logic [RES_W-1:0] e;
      @(negedge clk);
      a      = '0;
      a[192] = 1'b1;
      send(1, a, W'(2), n);
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL boundary_grant: req_ready=%b, want 10", req_ready);
      end
      wait_rsp(1'b1, lat, bad);
      e = '0;
`ifdef GF_REDUCE_EN
      e[15] = 1'b1;
      e[0]  = 1'b1;
`else
      e[193] = 1'b1;
`endif
      checks++;
      if (rsp_data !== e || rsp_id !== 1'b1 || lat != MC + EXTRA) begin
         failures++;
         $display("FAIL boundary_rsp: id=%0d lat=%0d data=%h, want 1 %0d %h",
                  rsp_id, lat, rsp_data, MC + EXTRA, e);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [W-1:0] ra [NREQ];
      logic [W-1:0] rb [NREQ];
      logic [NREQ-1:0] one;
      int lat, bad, g;
      one   = 1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         ra[i] = rnd();
         rb[i] = rnd();
         req_a[i*W +: W] = ra[i];
         req_b[i*W +: W] = rb[i];
      end
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      #1;
      for (int t = 0; t < 4; t++) begin
         g = t % 2;
         checks++;
         if (req_ready !== (one << g)) begin
            failures++;
            $display("FAIL rr_grant%0d: req_ready=%b, want %b",
                     t, req_ready, one << g);
         end
         wait_rsp(1'b0, lat, bad);
         checks++;
         if (bad != 0 || rsp_id !== IDW'(g)
             || rsp_data !== exp_res(ra[g], rb[g])) begin
            failures++;
            $display("FAIL rr_rsp%0d: id=%0d bad=%0d data=%h, want id=%0d %h",
                     t, rsp_id, bad, rsp_data, g, exp_res(ra[g], rb[g]));
         end
         @(negedge clk); #1;
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a0, b0, a1, b1;
      logic [IDW-1:0] id0;
      logic [RES_W-1:0] d0;
      int n, lat, bad, unstable;
      @(negedge clk);
      rsp_ready = 1'b0;
      a0 = rnd();
      b0 = rnd();
      send(0, a0, b0, n);
      wait_rsp(1'b1, lat, bad);
      id0 = rsp_id;
      d0  = rsp_data;
      checks++;
      if (id0 !== 1'b0 || d0 !== exp_res(a0, b0)) begin
         failures++;
         $display("FAIL bp_first: id=%0d data=%h, want 0 %h",
                  id0, d0, exp_res(a0, b0));
      end
      a1 = rnd();
      b1 = rnd();
      req_a[W +: W] = a1;
      req_b[W +: W] = b1;
      req_valid[1]  = 1'b1;
      unstable = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_data !== d0
             || req_ready !== 2'b00) unstable++;
      end
      checks++;
      if (unstable != 0) begin
         failures++;
         $display("FAIL bp_hold: unstable cycles=%0d, want 0", unstable);
      end
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
         failures++;
         $display("FAIL bp_release: valid=%b req_ready=%b, want 0 10",
                  rsp_valid, req_ready);
      end
      wait_rsp(1'b1, lat, bad);
      checks++;
      if (rsp_id !== 1'b1 || rsp_data !== exp_res(a1, b1)
          || lat != MC + EXTRA) begin
         failures++;
         $display("FAIL bp_next: id=%0d lat=%0d data=%h, want 1 %0d %h",
                  rsp_id, lat, rsp_data, MC + EXTRA, exp_res(a1, b1));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] a0, b0;
      int n, lat, bad, leak;
      @(negedge clk);
      send(0, rnd(), rnd(), n);
      @(negedge clk);
      a0 = rnd();
      b0 = rnd();
      req_a[W-1:0] = a0;
      req_b[W-1:0] = b0;
      req_a[W +: W] = rnd();
      req_b[W +: W] = rnd();
      req_valid = 2'b11;
      rst_n     = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, busy} !== 4'b0 || mul_a !== '0
          || mul_b !== '0 || rsp_id !== '0 || rsp_data !== '0) begin
         failures++;
         $display("FAIL midrst_clear: rdy=%b valid=%b busy=%b mul_a=%h data=%h",
                  req_ready, rsp_valid, busy, mul_a, rsp_data);
      end
      leak = 0;
      repeat (2) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b0 || req_ready !== 2'b00) leak++;
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (leak != 0 || req_ready !== 2'b01) begin
         failures++;
         $display("FAIL midrst_first: req_ready=%b leak=%0d, want 01 0",
                  req_ready, leak);
      end
      wait_rsp(1'b1, lat, bad);
      checks++;
      if (rsp_id !== 1'b0 || rsp_data !== exp_res(a0, b0)
          || lat != MC + EXTRA) begin
         failures++;
         $display("FAIL midrst_rsp: id=%0d lat=%0d data=%h, want 0 %0d %h",
                  rsp_id, lat, rsp_data, MC + EXTRA, exp_res(a0, b0));
      end
      @(negedge clk);
   endtask

   task automatic test_timing_edge();
      int k;
      @(negedge clk);
      rsp_ready_e        = 1'b1;
      req_a_e[W-1:0]     = W'(3);
      req_b_e[W-1:0]     = W'(3);
      req_valid_e        = 2'b01;
      #1;
      checks++;
      if (req_ready_e !== 2'b01) begin
         failures++;
         $display("FAIL edge_grant: req_ready=%b, want 01", req_ready_e);
      end
      @(negedge clk);
      req_valid_e = '0;
      #1;
      k = 1;
      while (!rsp_valid_e && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      checks++;
      if (k - 1 != 1 + EXTRA) begin
         failures++;
         $display("FAIL edge_latency: lat=%0d, want %0d", k - 1, 1 + EXTRA);
      end
      checks++;
      if (rsp_data_e !== RES_W'(5) || rsp_id_e !== 1'b0) begin
         failures++;
         $display("FAIL edge_data: id=%0d data=%h, want 0 5",
                  rsp_id_e, rsp_data_e);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [W-1:0] ra [NREQ];
      logic [W-1:0] rb [NREQ];
      logic [NREQ-1:0] exp_rdy, clr;
      logic [IDW-1:0] eid;
      logic [RES_W-1:0] edata;
      int last, done, cyc, g;
      bit inflight, found;
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n    = 1'b1;
      last     = NREQ - 1;
      inflight = 1'b0;
      done     = 0;
      cyc      = 0;
      clr      = '0;
      eid      = '0;
      edata    = '0;
      g        = 0;
      while (done < 30 && cyc < 4000) begin
         @(negedge clk);
         req_valid = req_valid & ~clr;
         clr       = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               ra[i] = rnd();
               rb[i] = rnd();
               req_a[i*W +: W] = ra[i];
               req_b[i*W +: W] = rb[i];
               req_valid[i]    = 1'b1;
            end
         end
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = '0;
         if (!inflight && req_valid != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
               if (!found && req_valid[(last + k) % NREQ]) begin
                  found = 1'b1;
                  g     = (last + k) % NREQ;
               end
            end
            exp_rdy[g] = 1'b1;
         end
         checks++;
         if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL rand_ready cyc%0d: req_ready=%b, want %b",
                     cyc, req_ready, exp_rdy);
         end
         if (exp_rdy != '0) begin
            inflight = 1'b1;
            last     = g;
            eid      = IDW'(g);
            edata    = exp_res(ra[g], rb[g]);
            clr      = exp_rdy;
         end else if (rsp_valid) begin
            checks++;
            if (!inflight || rsp_id !== eid || rsp_data !== edata) begin
               failures++;
               $display("FAIL rand_rsp cyc%0d: id=%0d data=%h, want %0d %h",
                        cyc, rsp_id, rsp_data, eid, edata);
            end
            if (rsp_ready) begin
               inflight = 1'b0;
               done++;
            end
         end
         cyc++;
      end
      checks++;
      if (done != 30) begin
         failures++;
         $display("FAIL rand_count: responses=%0d, want 30", done);
      end
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      rsp_ready   = 1'b1;
      req_valid_e = '0;
      req_a_e     = '0;
      req_b_e     = '0;
      rsp_ready_e = 1'b1;
      test_reset();
      test_basic();
      test_reduce_boundary();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_timing_edge();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
